// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-byte holding register
module uart_tx #(
  parameter int CLK_FREQ  = 65_000_000,
  parameter int BAUD_RATE = 9_600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       TxD,
  output logic       busy,
  output logic       tx_done
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  // A bit period shorter than two clocks cannot be counted meaningfully.
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_valid_q, hold_valid_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          tx_done_q, tx_done_d;
  logic          baud_end;

  assign baud_end = (baud_cnt_q == BAUD_LAST);

  // State and datapath registers; reset drops any byte in flight or held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
    end
  end

  // Next-state logic: handshake into hold, frame sequencing, and registered line outputs.
  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_done_d    = 1'b0;

    // Accept only into an empty hold; a transfer out needs a full hold, so the two never coincide.
    if (in_valid && !hold_valid_q) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
          baud_cnt_d   = '0;
          bit_cnt_d    = '0;
          state_d      = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          tx_done_d  = 1'b1;
          if (hold_valid_q) begin
            // Chain straight into the next start bit so the line never idles between frames.
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            bit_cnt_d    = '0;
            state_d      = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so TxD is a clean register output.
    txd_d = 1'b1;
    if (state_d == START) begin
      txd_d = 1'b0;
    end else if (state_d == DATA) begin
      txd_d = shift_d[0];
    end
    busy_d = (state_d != IDLE);
  end

  assign in_ready = !hold_valid_q;
  assign TxD      = txd_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx at DIV=10
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       TxD;
  logic       busy;
  logic       tx_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_tx #(
    .CLK_FREQ (100),
    .BAUD_RATE(10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .TxD     (TxD),
    .busy    (busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte to an empty hold; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input string tag);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_accept"}, 32'(in_ready), 32'd0);
  endtask

  // Wait for the start bit, check all 100 line cycles, then the tx_done pulse.
  // Returns at the tx_done negedge, which is start cycle 0 of a chained frame.
  task automatic check_frame(input logic [7:0] b, input string tag, output int st);
    int          w;
    logic        eb;
    logic [2:0]  idx;
    w  = 0;
    st = -1;
    while (TxD !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start"}, 32'(TxD), 32'd0);
    if (TxD !== 1'b0) return;
    st = cyc;
    for (int c = 0; c < 100; c++) begin
      if (c < 10) begin
        eb = 1'b0;
      end else if (c < 90) begin
        idx = 3'(c / 10 - 1);
        eb  = b[idx];
      end else begin
        eb = 1'b1;
      end
      chk($sformatf("%s_line_c%0d", tag, c), 32'(TxD), 32'(eb));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'd1);
      if (c > 0) chk($sformatf("%s_done_c%0d", tag, c), 32'(tx_done), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_tx_done"}, 32'(tx_done), 32'd1);
  endtask

  int s1, s2, s3, acc_cyc, lows;

  initial begin
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;

    // Reset with no clock edge
    #2 rst = 1'b0;
    #1;
    chk("rst_txd",      32'(TxD),      32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tx_done",  32'(tx_done),  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x55
    send(8'h55, "b55");
    acc_cyc = cyc;
    chk("b55_txd_before_fall", 32'(TxD),  32'd1);
    chk("b55_busy_before",     32'(busy), 32'd0);
    @(negedge clk);
    chk("b55_in_ready_back", 32'(in_ready), 32'd1);
    check_frame(8'h55, "b55", s1);
    chk("b55_latency", 32'(s1), 32'(acc_cyc + 1));
    chk("b55_busy_fall",  32'(busy), 32'd0);
    chk("b55_txd_idle",   32'(TxD),  32'd1);
    @(negedge clk);
    chk("b55_done_single", 32'(tx_done), 32'd0);
    repeat (5) @(negedge clk);

    // Back-to-back 0xA5 then 0x3C
    send(8'hA5, "bbA5");
    fork
      begin
        check_frame(8'hA5, "bb1", s1);
        check_frame(8'h3C, "bb2", s2);
      end
      begin
        repeat (30) @(negedge clk);
        chk("bb_ready_before", 32'(in_ready), 32'd1);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bb_accept_3c", 32'(in_ready), 32'd0);
      end
    join
    chk("bb_no_gap",    32'(s2), 32'(s1 + 100));
    chk("bb_busy_fall", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Stall: hold full while in_valid stays high and in_data changes
    send(8'h81, "st81");
    fork
      begin
        check_frame(8'h81, "st1", s1);
        check_frame(8'h44, "st2", s2);
        check_frame(8'h22, "st3", s3);
      end
      begin
        repeat (20) @(negedge clk);
        in_data  = 8'h44;
        in_valid = 1'b1;
        @(negedge clk);
        chk("st_hold_full", 32'(in_ready), 32'd0);
        in_data = 8'h11;
        repeat (50) @(negedge clk);
        chk("st_still_full", 32'(in_ready), 32'd0);
        in_data = 8'h22;
        for (int w = 0; w < 300 && in_ready !== 1'b1; w++) @(negedge clk);
        chk("st_ready_rise", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("st_accept_22", 32'(in_ready), 32'd0);
      end
    join
    chk("st_chain12", 32'(s2), 32'(s1 + 100));
    chk("st_chain23", 32'(s3), 32'(s2 + 100));
    lows = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("st_sent_once", 32'(lows), 32'd0);

    // Reset mid-frame during data bit 3 of 0xF0, with a byte also held
    send(8'hF0, "rsF0");
    repeat (10) @(negedge clk);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_hold_full", 32'(in_ready), 32'd0);
    repeat (34) @(negedge clk);
    chk("rs_pre_bit3", 32'(TxD), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("rs_txd_async", 32'(TxD),      32'd1);
    chk("rs_busy",      32'(busy),     32'd0);
    chk("rs_in_ready",  32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rs_idle_after", 32'(TxD), 32'd1);
    send(8'hFF, "rsFF");
    check_frame(8'hFF, "rsFF", s1);
    chk("rs_busy_end", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Extremes
    send(8'h00, "x00");
    check_frame(8'h00, "x00", s1);
    repeat (3) @(negedge clk);
    send(8'hFF, "xFF");
    check_frame(8'hFF, "xFF", s1);
    chk("x_busy_end", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
